seq_mult: RTL and testbench



---
 rtl/seq_mult.sv | 121 ++++++++++++
 tb/tb_seq_mult.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle, with an
// unsigned or signed-magnitude mode. Define SEQ_MULT_EARLY_TERM_EN for data-dependent latency.
module seq_mult #(
  parameter int unsigned A_WIDTH        = 16,
  parameter int unsigned B_WIDTH        = 8,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [A_WIDTH-1:0]         multiplicand,
  input  logic [B_WIDTH-1:0]         multiplier,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int unsigned K       = BITS_PER_CYCLE;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [P_WIDTH-1:0] a_q, acc_q, product_q;
  logic [B_WIDTH-1:0] b_q;
  logic               neg_q, done_q;

  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag, b_shift;
  logic [P_WIDTH-1:0] digit, acc_sum;
  logic               accept, run_last;

`ifndef SEQ_MULT_EARLY_TERM_EN
  localparam int unsigned Steps = (B_WIDTH + K - 1) / K;
  localparam int unsigned CntW  = $clog2(Steps + 1);
  logic [CntW-1:0] cnt_q;
`endif

  // Operands are reduced to magnitudes up front; the sign is re-applied once at the end.
  always_comb begin
    a_mag = multiplicand;
    b_mag = multiplier;
    if (signed_mode && multiplicand[A_WIDTH-1]) a_mag = -multiplicand;
    if (signed_mode && multiplier[B_WIDTH-1])   b_mag = -multiplier;
    digit   = P_WIDTH'(b_q[K-1:0]);
    acc_sum = acc_q + digit * a_q;
    b_shift = b_q >> K;
    // done_q marks the pulse cycle, which is spent in IDLE but must not accept a new start.
    accept  = (state_q == StIdle) && start && !done_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
    run_last = (b_shift == '0);
`else
    run_last = (cnt_q == CntW'(Steps - 1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
          state_d = (b_mag != '0) ? StRun : StDone;
`else
          state_d = StRun;
`endif
        end
      end
      StRun:   if (run_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle) || done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifndef SEQ_MULT_EARLY_TERM_EN
      cnt_q     <= '0;
`endif
    end else begin
      done_q <= (state_q == StDone);
      if (accept) begin
        a_q   <= P_WIDTH'(a_mag);
        b_q   <= b_mag;
        acc_q <= '0;
        neg_q <= signed_mode & (multiplicand[A_WIDTH-1] ^ multiplier[B_WIDTH-1]);
`ifndef SEQ_MULT_EARLY_TERM_EN
        cnt_q <= '0;
`endif
      end else if (state_q == StRun) begin
        acc_q <= acc_sum;
        a_q   <= a_q << K;
        b_q   <= b_shift;
`ifndef SEQ_MULT_EARLY_TERM_EN
        cnt_q <= cnt_q + CntW'(1);
`endif
      end
      if (state_q == StDone) product_q <= neg_q ? -acc_q : acc_q;
    end
  end

  assign product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: expected products and latencies are queued at issue time and
// checked when the done pulse appears.
module tb_seq_mult;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned K  = 2;
  localparam int unsigned PW = AW + BW;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EarlyTerm = 1'b1;
`else
  localparam bit EarlyTerm = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] prod;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [AW-1:0] multiplicand = '0;
  logic [BW-1:0] multiplier = '0;
  logic [PW-1:0] product;
  logic          busy, done;

  exp_t          sb_q[$];
  logic [PW-1:0] last_prod = '0;
  int            errors = 0;
  int            checks = 0;

  seq_mult #(
    .A_WIDTH       (AW),
    .B_WIDTH       (BW),
    .BITS_PER_CYCLE(K)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [AW-1:0] a, input logic [BW-1:0] b, input bit s);
    exp_t   e;
    longint av, bv;
    int     bm, msb;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    e.prod = PW'(av * bv);
    bm  = (s && b[BW-1]) ? (1 << BW) - int'(b) : int'(b);
    msb = -1;
    for (int i = 0; i <= BW; i++) if (((bm >> i) & 1) != 0) msb = i;
    if (!EarlyTerm)   e.lat = (BW + K - 1) / K + 1;
    else if (bm == 0) e.lat = 1;
    else              e.lat = (msb + K) / K + 1;
    return e;
  endfunction

  // Drive a start for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b, input bit s);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = s;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back(model(a, b, s));
    multiplicand = AW'($urandom);
    multiplier   = BW'($urandom);
    signed_mode  = 1'($urandom);
  endtask

  // Waits for done (bounded), counting edges from the accepting edge; then checks the pulse ends.
  task automatic wait_done(input string tag, input int already);
    exp_t e;
    int   lat;
    lat = 0;
    for (int cyc = already + 1; cyc <= already + 40; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc;
        break;
      end
      check({tag, "_hold"}, product, last_prod);
    end
    check({tag, "_sb_pending"}, sb_q.size(), 1);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '{prod: '0, lat: -1};
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_product"}, product, e.prod);
    check({tag, "_busy_done"}, busy, 1'b1);
    last_prod = e.prod;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  int done_seen;

  initial begin
    #2 rst = 1'b1;
    #2;
    check("rst_product", product, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 8'h05, 1'b0);
    wait_done("u_1234x05", 0);
    issue(16'hFFFD, 8'h07, 1'b1);
    wait_done("s_m3x7", 0);
    issue(16'hFFFD, 8'h07, 1'b0);
    wait_done("u_fffdx07", 0);
    issue(16'h8000, 8'h80, 1'b1);
    wait_done("s_minxmin", 0);
    issue(16'h1234, 8'h00, 1'b0);
    wait_done("b_zero", 0);
    issue(16'h0000, 8'h55, 1'b0);
    wait_done("a_zero", 0);
    issue(16'h7FFF, 8'h81, 1'b1);
    wait_done("s_max_x_neg", 0);

    // Start pulsed mid-RUN and held through done: first op unaffected, second one accepted
    // only on the cycle after the done pulse.
    issue(16'h00FF, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    multiplicand = 16'hFFFF;
    multiplier   = 8'h03;
    signed_mode  = 1'b1;
    start        = 1'b1;
    wait_done("midrun_first", 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midrun_accept_busy", busy, 1'b1);
    sb_q.push_back(model(16'hFFFF, 8'h03, 1'b1));
    wait_done("midrun_second", 0);

    // Asynchronous reset in the middle of RUN.
    issue(16'h1234, 8'h05, 1'b0);
    wait_done("pre_rst", 0);
    @(negedge clk);
    multiplicand = 16'h00FF;
    multiplier   = 8'hFF;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_product", product, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    check("arst_product_held", product, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
